// File: rtl/apb_selftest_master.sv
// APB3 master that writes a pattern to NUM_WORDS words, reads it back and reports passed/failed.
// Optional feature: define APB_SLVERR_CHK_EN to treat pslverr at completion as a failure.
module apb_selftest_master #(
    parameter int NUM_WORDS = 8,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              passed,
    output logic              failed,
    output logic [ADDR_W-1:0] fail_addr
);
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, PASS, FAIL} state_t;

    state_t            state, state_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic              rd_ph, rd_ph_nx;
    logic [TMO_W-1:0]  tmo_cnt, tmo_nx;
    logic [ADDR_W-1:0] fail_addr_nx;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_pat;
    logic [31:0]       pat32;
    logic              last;
    logic              slv_err;

    assign pat32    = 32'hA5A5_0000 + 32'(idx);
    assign cur_pat  = DATA_W'(pat32);
    assign cur_addr = ADDR_W'({idx, 2'b00});
    assign last     = (idx == IDX_W'(NUM_WORDS - 1));

`ifdef APB_SLVERR_CHK_EN
    assign slv_err = pslverr;
`else
    logic unused_pslverr;
    assign unused_pslverr = pslverr;
    assign slv_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            rd_ph     <= 1'b0;
            tmo_cnt   <= '0;
            fail_addr <= '0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            rd_ph     <= rd_ph_nx;
            tmo_cnt   <= tmo_nx;
            fail_addr <= fail_addr_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        rd_ph_nx     = rd_ph;
        tmo_nx       = tmo_cnt;
        fail_addr_nx = fail_addr;
        psel         = 1'b0;
        penable      = 1'b0;
        pwrite       = 1'b0;
        paddr        = '0;
        pwdata       = '0;
        case (state)
            IDLE: state_nx = SETUP;
            SETUP: begin
                psel     = 1'b1;
                pwrite   = ~rd_ph;
                paddr    = cur_addr;
                pwdata   = rd_ph ? '0 : cur_pat;
                tmo_nx   = '0;
                state_nx = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                pwrite  = ~rd_ph;
                paddr   = cur_addr;
                pwdata  = rd_ph ? '0 : cur_pat;
                // Completion wins over a timeout landing in the same cycle.
                if (pready) begin
                    if ((rd_ph && (prdata != cur_pat)) || slv_err) begin
                        state_nx     = FAIL;
                        fail_addr_nx = cur_addr;
                    end else if (!last) begin
                        idx_nx   = idx + IDX_W'(1);
                        state_nx = SETUP;
                    end else if (!rd_ph) begin
                        rd_ph_nx = 1'b1;
                        idx_nx   = '0;
                        state_nx = SETUP;
                    end else begin
                        state_nx = PASS;
                    end
                end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    state_nx     = FAIL;
                    fail_addr_nx = cur_addr;
                end else begin
                    tmo_nx = tmo_cnt + TMO_W'(1);
                end
            end
            default: state_nx = state;
        endcase
    end

    assign passed = (state == PASS);
    assign failed = (state == FAIL);
endmodule

// File: tb/tb_apb_selftest_master.sv
// Bench for apb_selftest_master: scratch-memory APB slave with fault injection plus transfer scoreboard.
module tb_apb_selftest_master;
    localparam int NW = 8;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;
    logic        passed, failed;
    logic [7:0]  fail_addr;

    int total = 0;
    int bad = 0;

    // slave configuration
    int wait_n = 0;
    int bad_addr = -1;
    int err_addr = -1;
    bit never_ready = 1'b0;
    int wcnt = 0;
    logic [31:0] mem [0:63];

    // expected transfers: {pwrite, paddr, pwdata}
    logic [40:0] exp_q[$];

    always #5 clk = ~clk;

    apb_selftest_master #(.NUM_WORDS(NW), .ADDR_W(8), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .passed(passed), .failed(failed), .fail_addr(fail_addr)
    );

    assign pready  = psel && penable && !never_ready && (wcnt >= wait_n);
    assign prdata  = (psel && penable && !pwrite) ?
                     ((int'(paddr) == bad_addr) ? 32'hDEAD_BEEF : mem[paddr[7:2]]) : 32'h0;
    assign pslverr = psel && penable && pwrite && (int'(paddr) == err_addr);

    always @(posedge clk) begin
        if (psel && penable && !pready) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (psel && penable && pready && pwrite) mem[paddr[7:2]] <= pwdata;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: transfer scoreboard and ACCESS-phase stability
    logic [40:0] setup_v;
    always @(negedge clk) begin
        if (!reset && psel && !penable) setup_v = {pwrite, paddr, pwdata};
        if (!reset && psel && penable) begin
            check("access_stable", {23'h0, pwrite, paddr, pwdata}, {23'h0, setup_v});
            if (pready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer", 64'(paddr), 64'hFFFF);
                end else begin
                    logic [40:0] e;
                    e = exp_q.pop_front();
                    check("xfer", {23'h0, pwrite, paddr, pwdata}, {23'h0, e});
                end
            end
        end
    end

    // reference model: the transfer list of a sweep
    task automatic push_sweep(input int n_wr, input int n_rd);
        for (int i = 0; i < n_wr; i++) exp_q.push_back({1'b1, 8'(4 * i), 32'hA5A5_0000 + 32'(i)});
        for (int i = 0; i < n_rd; i++) exp_q.push_back({1'b0, 8'(4 * i), 32'h0});
    endtask

    task automatic start(input int w, input int ba, input bit nr, input int ea);
        reset = 1'b1;
        wait_n = w; bad_addr = ba; never_ready = nr; err_addr = ea;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'({psel, penable, pwrite, passed, failed, paddr, pwdata, fail_addr}), 64'h0);
        reset = 1'b0;
    endtask

    task automatic finish_run(input string name, input bit exp_pass, input int exp_fa, input int exp_cyc);
        int cyc;
        cyc = 0;
        while (!(passed || failed) && cyc < 3000) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        check({name, "_done"}, 64'(passed | failed), 64'h1);
        check({name, "_cycles"}, 64'(cyc), 64'(exp_cyc));
        check({name, "_passed"}, 64'(passed), 64'(exp_pass));
        check({name, "_failed"}, 64'(failed), 64'(!exp_pass));
        check({name, "_fail_addr"}, 64'(fail_addr), exp_pass ? 64'h0 : 64'(exp_fa));
        repeat (3) @(posedge clk);
        #1;
        check({name, "_terminal"}, 64'({psel, penable, passed, failed}), 64'({2'b00, exp_pass, !exp_pass}));
        check({name, "_q_empty"}, 64'(exp_q.size()), 64'h0);
        exp_q.delete();
    endtask

    initial begin
        int w, k, cyc;
        // zero-wait pass
        push_sweep(NW, NW);
        start(0, -1, 1'b0, -1);
        finish_run("zero_wait", 1'b1, 0, 1 + 4 * NW);
        // three wait states
        push_sweep(NW, NW);
        start(3, -1, 1'b0, -1);
        finish_run("wait3", 1'b1, 0, 1 + 2 * NW * 5);
        // bad read data at 0x0C
        push_sweep(NW, 4);
        start(0, 'h0C, 1'b0, -1);
        finish_run("bad_data", 1'b0, 'h0C, 1 + (NW + 4) * 2);
        // slave never ready
        start(0, -1, 1'b1, -1);
        finish_run("timeout", 1'b0, 'h00, 2 + TO);
        // slave error on write to 0x08
`ifdef APB_SLVERR_CHK_EN
        push_sweep(3, 0);
        start(0, -1, 1'b0, 'h08);
        finish_run("slverr", 1'b0, 'h08, 1 + 3 * 2);
`else
        push_sweep(NW, NW);
        start(0, -1, 1'b0, 'h08);
        finish_run("slverr", 1'b1, 0, 1 + 4 * NW);
`endif
        // reset pulse during ACCESS of the read of 0x10
        push_sweep(NW, NW);
        start(2, -1, 1'b0, -1);
        cyc = 0;
        while (!(psel && penable && !pwrite && paddr == 8'h10) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_found", 64'(psel && penable && !pwrite && paddr == 8'h10), 64'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset_outputs", 64'({psel, penable, pwrite, passed, failed, paddr, pwdata, fail_addr}), 64'h0);
        check("mid_pending", 64'(exp_q.size()), 64'(NW - 4));
        exp_q.delete();
        push_sweep(NW, NW);
        reset = 1'b0;
        finish_run("mid_rerun", 1'b1, 0, 1 + 2 * NW * 4);
        // randomized wait states and fault location
        for (int r = 0; r < 4; r++) begin
            w = $urandom_range(0, 4);
            k = $urandom_range(0, NW);
            if (k == NW) begin
                push_sweep(NW, NW);
                start(w, -1, 1'b0, -1);
                finish_run("rand_pass", 1'b1, 0, 1 + 2 * NW * (2 + w));
            end else begin
                push_sweep(NW, k + 1);
                start(w, 4 * k, 1'b0, -1);
                finish_run("rand_fail", 1'b0, 4 * k, 1 + (NW + k + 1) * (2 + w));
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
